mem_arbiter: RTL
================

# mem_arbiter

Arbitrates a single-port, pipelined, word-wide main memory between the I-cache and D-cache miss handlers. Each requester issues either a block fill (BLOCK_WORDS consecutive reads) or, for the D-side only, a single-word write-through. A small FSM sequences the memory port, tracks in-flight reads across the memory latency, and returns fill data word by word with its index. It sits between the two cache controllers and the main data memory.

## Interface
- ADDR_WIDTH, 16, byte-address width.
- MEM_LAT, 4, memory read latency in cycles (>=1). mem_rdata for a read issued in cycle t is valid in cycle t+MEM_LAT.
- BLOCK_WORDS, 8, 16-bit words per cache block (power of two, >=2). IW = log2(BLOCK_WORDS).
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- i_req / d_req  in  1  request, level-held until the matching done.
- i_addr / d_addr  in  ADDR_WIDTH  byte address.
- d_wr  in  1  D request is a word write (0 = block fill).
- d_wdata  in  16  write data.
- i_grant / d_grant  out  1  one-cycle pulse when the transaction starts.
- i_rvalid / d_rvalid  out  1  fill word valid.
- i_rdata / d_rdata  out  16  fill word; 0 when rvalid=0.
- i_widx / d_widx  out  IW  word index within the block.
- i_done / d_done  out  1  one-cycle pulse on transaction completion.
- mem_addr  out  ADDR_WIDTH; mem_en  out  1; mem_wr  out  1; mem_wdata  out  16  memory port.
- mem_rdata  in  16  memory read data.
- busy  out  1  FSM not in IDLE.

## Operation
- States: IDLE, ISSUE, DRAIN, WRITE.
- IDLE: sample the requests. If neither is high, stay. Otherwise pick the winner per Configuration.
  - Winner is D with d_wr=1: go to WRITE.
  - Otherwise: go to ISSUE with counter k=0 and base = addr with bits [IW:0] cleared.
- ISSUE: drive mem_en=1, mem_wr=0, mem_addr = base + 2k, then k++. After k = BLOCK_WORDS-1 has been issued, go to DRAIN.
- DRAIN: wait until the last in-flight read returns, then go to IDLE.
- WRITE: drive mem_en=1, mem_wr=1, mem_addr = d_addr with bit0 cleared, mem_wdata = d_wdata. Go to IDLE.
- In-flight tracking: a MEM_LAT-deep shift register carries {valid, owner, idx}. On a valid exit, assert the owner's rvalid with rdata = mem_rdata and widx = idx. Assert done with the idx = BLOCK_WORDS-1 word.
- Address arithmetic is modulo 2^ADDR_WIDTH; no carry out of the block is possible.
- Reads and writes never overlap: WRITE is entered only from IDLE, and IDLE is reached only after DRAIN empties.
- Requester contract: after seeing done, deassert req by the next clock edge. A req still high in IDLE starts a new transaction.
- Memory port signals are 0 when not driven.

## Timing
- Reset: synchronous. All outputs are 0, the FSM is IDLE, the shift register is cleared, and the round-robin pointer is set to "I last". Asserting rst mid-transaction aborts it: no further rvalid or done is produced, and in-flight data is discarded.
- Fill, with req first seen in IDLE at cycle 0:
  - grant and the first read in cycle 1; reads in cycles 1..BLOCK_WORDS.
  - rvalid in cycles 1+MEM_LAT .. BLOCK_WORDS+MEM_LAT; done in the last of these cycles.
  - IDLE in the following cycle.
- Write: grant, done and the memory write all in cycle 1; IDLE in cycle 2.
- Outputs are registered, except rdata, which passes mem_rdata through when rvalid=1.
- A request arriving while busy waits. There is no preemption.

## Configuration
- ARB_ROUND_ROBIN_EN defined: when both requesters are high in IDLE, the grant goes to the requester not served last. The pointer updates on every grant.
- ARB_ROUND_ROBIN_EN undefined: fixed priority; D always wins ties.
- In both modes, a lone requester is always served.

## Test plan
- Reset, then i_req=1 with i_addr=0x0036 (MEM_LAT=4, BLOCK_WORDS=8) -> reads at 0x0030..0x003E in cycles 1..8; i_rvalid in cycles 5..12 with widx 0..7; i_done in cycle 12.
- d_req=1, d_wr=1, d_addr=0x1235, d_wdata=0xBEEF -> cycle 1 shows mem_en=1, mem_wr=1, mem_addr=0x1234; d_done in cycle 1. A following D fill of 0x1230 returns 0xBEEF at widx 2.
- Simultaneous i_req and d_req, twice in a row -> with ARB_ROUND_ROBIN_EN the order is D, I; without it the order is D, D (I starves while D stays high).
- d_req rises in cycle 3 of an I fill -> D granted in the cycle after IDLE is reached (cycle 14); no memory activity overlaps.
- rst in cycle 6 of a fill -> cycle 7 shows all outputs 0 and busy=0; no rvalid or done appears afterwards.
- i_addr=0xFFF2 -> reads 0xFFF0..0xFFFE; no wrap outside the block.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester block-fill / write-through arbiter for a pipelined word-wide memory.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise the D side wins ties.
module mem_arbiter #(
   parameter int ADDR_WIDTH  = 16,
   parameter int MEM_LAT     = 4,
   parameter int BLOCK_WORDS = 8,
   localparam int IW         = $clog2(BLOCK_WORDS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic                  d_req,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic                  d_wr,
   input  logic [15:0]           d_wdata,
   output logic                  i_grant,
   output logic                  d_grant,
   output logic                  i_rvalid,
   output logic                  d_rvalid,
   output logic [15:0]           i_rdata,
   output logic [15:0]           d_rdata,
   output logic [IW-1:0]         i_widx,
   output logic [IW-1:0]         d_widx,
   output logic                  i_done,
   output logic                  d_done,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_en,
   output logic                  mem_wr,
   output logic [15:0]           mem_wdata,
   input  logic [15:0]           mem_rdata,
   output logic                  busy,
   output logic [1:0]            dbg_state
);

   // Handshake: req is level-held until its done pulse; grant pulses once when the
   // transaction is accepted; rvalid words carry no backpressure and must be taken.
   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, WRITE = 2'd3} state_t;

   localparam logic [ADDR_WIDTH-1:0] BLK_MASK = ~ADDR_WIDTH'((1 << (IW + 1)) - 1);
   localparam logic [IW-1:0]         LAST_IDX = IW'(BLOCK_WORDS - 1);

   state_t                state, state_n;
   logic [IW-1:0]         k, k_n;
   logic [ADDR_WIDTH-1:0] base, base_n;
   logic                  owner, owner_n;
   logic                  pick_d, any_req;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic                  i_grant_n, d_grant_n, wdone_n, push;
   logic                  mem_en_n, mem_wr_n;
   logic [ADDR_WIDTH-1:0] mem_addr_n;
   logic [15:0]           mem_wdata_n;

   // In-flight read tags: valid, owner (1 = D) and word index.
   logic [MEM_LAT-1:0]    sr_v, sr_o;
   logic [IW-1:0]         sr_idx [MEM_LAT];
   logic                  out_v, out_o, out_last;
   logic [IW-1:0]         out_idx;

   assign any_req  = i_req | d_req;
   assign sel_addr = pick_d ? d_addr : i_addr;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_d;

   always_ff @(posedge clk) begin
      if (rst)
         last_d <= 1'b0;
      else if (state == IDLE && any_req)
         last_d <= pick_d;
   end

   assign pick_d = d_req & (~i_req | ~last_d);
`else
   assign pick_d = d_req;
`endif

   always_comb begin
      state_n     = state;
      k_n         = k;
      base_n      = base;
      owner_n     = owner;
      i_grant_n   = 1'b0;
      d_grant_n   = 1'b0;
      wdone_n     = 1'b0;
      mem_en_n    = 1'b0;
      mem_wr_n    = 1'b0;
      mem_addr_n  = '0;
      mem_wdata_n = '0;
      case (state)
         IDLE: begin
            if (any_req) begin
               owner_n   = pick_d;
               i_grant_n = ~pick_d;
               d_grant_n = pick_d;
               mem_en_n  = 1'b1;
               if (pick_d && d_wr) begin
                  state_n     = WRITE;
                  wdone_n     = 1'b1;
                  mem_wr_n    = 1'b1;
                  mem_addr_n  = d_addr & ~ADDR_WIDTH'(1);
                  mem_wdata_n = d_wdata;
               end else begin
                  state_n    = ISSUE;
                  k_n        = '0;
                  base_n     = sel_addr & BLK_MASK;
                  mem_addr_n = base_n;
               end
            end
         end
         ISSUE: begin
            // k is the index of the read currently on the port.
            if (k == LAST_IDX) begin
               state_n = DRAIN;
            end else begin
               k_n        = k + 1'b1;
               mem_en_n   = 1'b1;
               mem_addr_n = base + ADDR_WIDTH'({k_n, 1'b0});
            end
         end
         DRAIN: begin
            if (i_done | d_done)
               state_n = IDLE;
         end
         WRITE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign push     = mem_en_n & ~mem_wr_n;
   assign out_v    = sr_v[MEM_LAT-1];
   assign out_o    = sr_o[MEM_LAT-1];
   assign out_idx  = sr_idx[MEM_LAT-1];
   assign out_last = (out_idx == LAST_IDX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         k         <= '0;
         base      <= '0;
         owner     <= 1'b0;
         i_grant   <= 1'b0;
         d_grant   <= 1'b0;
         mem_en    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         sr_v      <= '0;
         sr_o      <= '0;
         for (int i = 0; i < MEM_LAT; i++)
            sr_idx[i] <= '0;
         i_rvalid  <= 1'b0;
         d_rvalid  <= 1'b0;
         i_widx    <= '0;
         d_widx    <= '0;
         i_done    <= 1'b0;
         d_done    <= 1'b0;
      end else begin
         state     <= state_n;
         k         <= k_n;
         base      <= base_n;
         owner     <= owner_n;
         i_grant   <= i_grant_n;
         d_grant   <= d_grant_n;
         mem_en    <= mem_en_n;
         mem_wr    <= mem_wr_n;
         mem_addr  <= mem_addr_n;
         mem_wdata <= mem_wdata_n;
         // Tag enters one cycle before the read is on the port, so the last stage
         // lines up with the cycle before the data returns.
         for (int i = MEM_LAT - 1; i > 0; i--) begin
            sr_v[i]   <= sr_v[i-1];
            sr_o[i]   <= sr_o[i-1];
            sr_idx[i] <= sr_idx[i-1];
         end
         sr_v[0]   <= push;
         sr_o[0]   <= owner_n;
         sr_idx[0] <= k_n;
         i_rvalid  <= out_v & ~out_o;
         d_rvalid  <= out_v & out_o;
         i_widx    <= (out_v & ~out_o) ? out_idx : '0;
         d_widx    <= (out_v & out_o) ? out_idx : '0;
         i_done    <= out_v & ~out_o & out_last;
         d_done    <= (out_v & out_o & out_last) | wdone_n;
      end
   end

   assign i_rdata   = i_rvalid ? mem_rdata : 16'h0000;
   assign d_rdata   = d_rvalid ? mem_rdata : 16'h0000;
   assign busy      = (state != IDLE);
   assign dbg_state = state;

endmodule
